// File: rtl/ann_seq_if.sv
// ann_seq_if: the bus between the ANN controller side and ann_layer_sequencer.
// It carries the layer start pulse, the issue gating inputs, the MAC-array
// controls and the completion pulse.
// Optional build macro ANN_SEQ_PERF_CNT_EN adds the stall_cycles counter signal.
interface ann_seq_if #(
  parameter int IDX_W = 7
);
  logic             reset_accum;
  logic             coeff_ready;
  logic [IDX_W-1:0] max_input;
  logic             mac_ready;
  logic [IDX_W-1:0] input_index;
  logic             mac_enable;
  logic             clear_accum;
  logic             apply_activation;
  logic             n_start_done;
  logic             busy;
`ifdef ANN_SEQ_PERF_CNT_EN
  logic [15:0]      stall_cycles;

  modport master (
    output reset_accum, coeff_ready, max_input, mac_ready,
    input  input_index, mac_enable, clear_accum, apply_activation,
           n_start_done, busy, stall_cycles
  );

  modport slave (
    input  reset_accum, coeff_ready, max_input, mac_ready,
    output input_index, mac_enable, clear_accum, apply_activation,
           n_start_done, busy, stall_cycles
  );
`else
  modport master (
    output reset_accum, coeff_ready, max_input, mac_ready,
    input  input_index, mac_enable, clear_accum, apply_activation,
           n_start_done, busy
  );

  modport slave (
    input  reset_accum, coeff_ready, max_input, mac_ready,
    output input_index, mac_enable, clear_accum, apply_activation,
           n_start_done, busy
  );
`endif
endinterface

// File: rtl/ann_layer_sequencer.sv
// ann_layer_sequencer: runs one layer pass per reset_accum pulse.
// The pass sequence is: clear the accumulators, then stream the input indices
// to the MAC array, then drain the MAC pipeline, then strobe activation, and
// finally pulse n_start_done.
// n_start_done is active-high; its name is historical.
// Optional build macro ANN_SEQ_PERF_CNT_EN adds the stall_cycles counter.
module ann_layer_sequencer #(
  parameter int IDX_W      = 7,
  parameter int MAX_INPUTS = 64,
  parameter int PIPE_DEPTH = 2
) (
  input  logic    clk,
  input  logic    n_rst,
  ann_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_STREAM   = 3'd2,
    S_DRAIN    = 3'd3,
    S_ACTIVATE = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] MAX_IN_C   = IDX_W'(MAX_INPUTS);
  localparam logic [IDX_W-1:0] ONE_C      = IDX_W'(1);
  // A zero-depth pipeline still spends one cycle in DRAIN.
  localparam logic [3:0]       LAST_DRAIN = (PIPE_DEPTH == 0) ? 4'd0 : 4'(PIPE_DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] limit_q, limit_d;
  logic [3:0]       drain_q, drain_d;
  logic [IDX_W-1:0] limit_in_s;
  logic             mac_en_s;

  assign limit_in_s = (bus.max_input > MAX_IN_C) ? MAX_IN_C : bus.max_input;
  // An issue happens only while streaming, and only when both operands and the MAC array are ready.
  assign mac_en_s   = (state_q == S_STREAM) & bus.coeff_ready & bus.mac_ready;

  // Next-state logic for the state, the index counter, the latched limit and the drain counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    limit_d = limit_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        idx_d   = {IDX_W{1'b0}};
        drain_d = 4'd0;
        if (limit_q == {IDX_W{1'b0}}) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (mac_en_s) begin
          if (idx_q == (limit_q - ONE_C)) begin
            state_d = S_DRAIN;
            drain_d = 4'd0;
          end else begin
            idx_d = idx_q + ONE_C;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = S_ACTIVATE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      S_ACTIVATE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A start pulse in any state restarts the pass with a freshly latched limit.
    if (bus.reset_accum) begin
      state_d = S_CLEAR;
      limit_d = limit_in_s;
    end else begin
      limit_d = limit_q;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      limit_q <= {IDX_W{1'b0}};
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      limit_q <= limit_d;
      drain_q <= drain_d;
    end
  end

  assign bus.input_index      = idx_q;
  assign bus.mac_enable       = mac_en_s;
  assign bus.clear_accum      = (state_q == S_CLEAR);
  assign bus.apply_activation = (state_q == S_ACTIVATE);
  assign bus.n_start_done     = (state_q == S_DONE);
  assign bus.busy             = (state_q != S_IDLE);

`ifdef ANN_SEQ_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count streaming cycles without an issue; saturate, clear at each new pass.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_CLEAR) begin
      stall_d = 16'd0;
    end else if ((state_q == S_STREAM) && !mac_en_s && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// tb_ann_layer_sequencer: randomized and directed stimulus for the sequencer.
// A pass-level reference model turns the stimulus schedule into expected
// per-cycle outputs.
// Build with ANN_SEQ_PERF_CNT_EN to also check stall_cycles.
module tb_ann_layer_sequencer;

  localparam int N  = 3000;
  localparam int PD = 2;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_errors;
  int   cur_cyc;

  ann_seq_if #(.IDX_W(7)) bus_if ();

  ann_layer_sequencer #(
    .IDX_W     (7),
    .MAX_INPUTS(64),
    .PIPE_DEPTH(PD)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus_if)
  );

  // Stimulus schedule.
  bit         st [N];
  logic [6:0] mi [N];
  bit         cr [N];
  bit         mr [N];
  // Expected per-cycle outputs.
  bit e_mac [N];
  bit e_clr [N];
  bit e_act [N];
  bit e_done [N];
  bit e_busy [N];
  bit e_idxv [N];
  int e_idx [N];
  bit e_stv [N];
  int e_stall [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cur_cyc, obs, exp);
    end
  endtask

  // Pass-level model: each start produces clear, L issues on ready cycles,
  // a drain of PD cycles (min 1), activation, then done.
  // Everything after the next start is discarded, because that pass is aborted.
  task automatic build_model();
    int s2, lim, t, k, d_len;
    for (int s = 0; s < N; s++) begin
      if (st[s]) begin
        s2 = N;
        for (int j = s + 1; j < N; j++) begin
          if (st[j]) begin
            s2 = j;
            break;
          end
        end
        lim = (mi[s] > 7'd64) ? 64 : int'(mi[s]);
        if (s + 1 < N) begin
          e_clr[s+1]  = 1'b1;
          e_busy[s+1] = 1'b1;
        end
        t = s + 2;
        k = 0;
        while (k < lim && t <= s2 && t < N) begin
          e_busy[t] = 1'b1;
          e_idxv[t] = 1'b1;
          e_idx[t]  = k;
          if (cr[t] && mr[t]) begin
            e_mac[t] = 1'b1;
            k++;
          end
          t++;
        end
        if (k == lim) begin
          d_len = (PD > 0) ? PD : 1;
          for (int d = 0; d < d_len + 2; d++) begin
            if (t + d <= s2 && t + d < N) e_busy[t+d] = 1'b1;
          end
          if (t + d_len <= s2 && t + d_len < N) e_act[t+d_len] = 1'b1;
          if (t + d_len + 1 <= s2 && t + d_len + 1 < N) begin
            e_done[t+d_len+1]  = 1'b1;
            e_stv[t+d_len+1]   = 1'b1;
            e_stall[t+d_len+1] = (t - (s + 2)) - lim;
          end
        end
      end
    end
  endtask

  task automatic drive_idle();
    bus_if.reset_accum = 1'b0;
    bus_if.coeff_ready = 1'b1;
    bus_if.mac_ready   = 1'b1;
    bus_if.max_input   = 7'd0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_mac"},  32'(bus_if.mac_enable), 32'd0);
    check_val({tag, "_clr"},  32'(bus_if.clear_accum), 32'd0);
    check_val({tag, "_act"},  32'(bus_if.apply_activation), 32'd0);
    check_val({tag, "_done"}, 32'(bus_if.n_start_done), 32'd0);
    check_val({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    int c;
    n_checks = 0;
    n_errors = 0;
    cur_cyc  = -1;
    n_rst    = 1'b0;
    drive_idle();

    // Build the stimulus: directed scenarios first, then random passes.
    for (int i = 0; i < N; i++) begin
      st[i] = 1'b0;
      mi[i] = 7'($urandom_range(0, 127));
      cr[i] = (i < 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      mr[i] = (i < 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    st[5]   = 1'b1; mi[5]   = 7'd4;    // basic pass
    st[30]  = 1'b1; mi[30]  = 7'd3;    // stall on mac_ready
    mr[33]  = 1'b0; mr[34]  = 1'b0; mr[35] = 1'b0;
    st[60]  = 1'b1; mi[60]  = 7'd0;    // zero inputs
    st[80]  = 1'b1; mi[80]  = 7'd100;  // clamped to 64
    st[200] = 1'b1; mi[200] = 7'd8;    // aborted at index 3
    st[205] = 1'b1; mi[205] = 7'd2;
    st[230] = 1'b1; mi[230] = 7'd3;    // back-to-back start in DONE
    st[238] = 1'b1; mi[238] = 7'd5;
    c = 300;
    while (c < N - 300) begin
      st[c] = 1'b1;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: mi[c] = 7'($urandom_range(0, 10));
        5, 6, 7:       mi[c] = 7'($urandom_range(0, 80));
        default:       mi[c] = 7'($urandom_range(60, 127));
      endcase
      if ($urandom_range(0, 9) < 2) c += $urandom_range(1, 20);
      else                          c += $urandom_range(40, 220);
    end
    build_model();

    // Reset state.
    #2;
    check_quiet("rst");
    check_val("rst_idx", 32'(bus_if.input_index), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Main run: drive cycle c, check at the falling edge, then advance.
    for (int i = 0; i < N; i++) begin
      cur_cyc = i;
      bus_if.reset_accum = st[i];
      bus_if.max_input   = mi[i];
      bus_if.coeff_ready = cr[i];
      bus_if.mac_ready   = mr[i];
      @(negedge clk);
      check_val("mac_enable", 32'(bus_if.mac_enable), 32'(e_mac[i]));
      check_val("clear_accum", 32'(bus_if.clear_accum), 32'(e_clr[i]));
      check_val("apply_activation", 32'(bus_if.apply_activation), 32'(e_act[i]));
      check_val("n_start_done", 32'(bus_if.n_start_done), 32'(e_done[i]));
      check_val("busy", 32'(bus_if.busy), 32'(e_busy[i]));
      if (e_idxv[i]) check_val("input_index", 32'(bus_if.input_index), 32'(e_idx[i]));
`ifdef ANN_SEQ_PERF_CNT_EN
      if (e_stv[i]) check_val("stall_cycles", 32'(bus_if.stall_cycles), 32'(e_stall[i]));
`endif
      @(posedge clk);
      #1;
    end

    // Async reset mid-stream: start a 10-input pass and reset it at index 5.
    cur_cyc = N;
    drive_idle();
    bus_if.reset_accum = 1'b1;
    bus_if.max_input   = 7'd10;
    @(posedge clk);
    #1;
    bus_if.reset_accum = 1'b0;
    @(negedge clk);
    check_val("ar_clear", 32'(bus_if.clear_accum), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k <= 5; k++) begin
      cur_cyc++;
      @(negedge clk);
      check_val("ar_mac", 32'(bus_if.mac_enable), 32'd1);
      check_val("ar_idx", 32'(bus_if.input_index), 32'(k));
      if (k < 5) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    n_rst = 1'b0;
    #1;
    check_quiet("ar_now");
    check_val("ar_now_idx", 32'(bus_if.input_index), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cur_cyc++;
      @(negedge clk);
      check_quiet("ar_after");
      @(posedge clk);
      #1;
    end

    // Clean pass after the reset: 2 inputs, done 7 cycles after the start.
    bus_if.reset_accum = 1'b1;
    bus_if.max_input   = 7'd2;
    for (int k = 0; k <= 8; k++) begin
      cur_cyc++;
      @(negedge clk);
      check_val("pp_clr",  32'(bus_if.clear_accum), 32'(k == 1));
      check_val("pp_mac",  32'(bus_if.mac_enable), 32'(k == 2 || k == 3));
      check_val("pp_act",  32'(bus_if.apply_activation), 32'(k == 6));
      check_val("pp_done", 32'(bus_if.n_start_done), 32'(k == 7));
      check_val("pp_busy", 32'(bus_if.busy), 32'(k >= 1 && k <= 7));
      if (k == 2 || k == 3) check_val("pp_idx", 32'(bus_if.input_index), 32'(k - 2));
      @(posedge clk);
      #1;
      bus_if.reset_accum = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
